// File: rtl/decode_if.sv
// Handshake bundle between the fetch word stream, the decode stage and the
// microcode sequencer: input word channel, kill inputs and decoded output channel.
interface decode_if #(
  parameter int DATA_W = 16,
  parameter int CNT_W  = 2
);
  logic [15:0]       in_word;
  logic              in_sext;
  logic              in_valid;
  logic              in_ready;
  logic              flush;
  logic              exc_triggered;
  logic              out_valid;
  logic              out_ready;
  logic [2:0]        out_type;
  logic [2:0]        out_rd;
  logic [2:0]        out_rs0;
  logic [2:0]        out_rs1;
  logic [DATA_W-1:0] out_imm;
  logic              out_has_imm;
  logic [CNT_W-1:0]  out_npfx;
  logic              out_illegal;

  modport master (
    output in_word, in_sext, in_valid, flush, exc_triggered, out_ready,
    input  in_ready, out_valid, out_type, out_rd, out_rs0, out_rs1,
           out_imm, out_has_imm, out_npfx, out_illegal
  );

  modport slave (
    input  in_word, in_sext, in_valid, flush, exc_triggered, out_ready,
    output in_ready, out_valid, out_type, out_rd, out_rs0, out_rs1,
           out_imm, out_has_imm, out_npfx, out_illegal
  );
endinterface

// File: rtl/decode_stage.sv
// Registered instruction-decode stage with multi-word immediate prefixes and
// valid/ready flow control. Define DEC_SKID_EN for a 2-entry skid behind the bundle register.
module decode_stage #(
  parameter int DATA_W  = 16,
  parameter int EXT_MAX = 2,
  parameter int CNT_W   = 2
) (
  input logic     clk,
  input logic     rst,
  decode_if.slave bus
);

  typedef enum logic {IDLE, PFX} state_t;

  typedef struct packed {
    logic [2:0]        typ;
    logic [2:0]        rd;
    logic [2:0]        rs0;
    logic [2:0]        rs1;
    logic [DATA_W-1:0] imm;
    logic              has_imm;
    logic [CNT_W-1:0]  npfx;
    logic              illegal;
  } bundle_t;

  // Places the low field under the accumulated prefixes and fills everything
  // above the concatenation with the extension bit.
  function automatic logic [DATA_W-1:0] compose_imm(
    input logic [DATA_W-1:0] acc,
    input logic [8:0]        low,
    input int                lw,
    input int                npfx,
    input logic              ext
  );
    logic [DATA_W-1:0] r;
    int                w;
    r = (acc << lw) | DATA_W'(low);
    w = npfx * 9 + lw;
    for (int i = 0; i < DATA_W; i++) begin
      if (i >= w) r[i] = ext;
    end
    return r;
  endfunction

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] acc;
  logic              pfx_sign;

  logic              kill;
  logic              accept;
  logic              in_ready_p0;

  logic              is_pfx_p0;
  logic              full_p0;
  logic              emit_p0;
  logic              t3_p0;
  logic              has_imm_p0;
  logic [8:0]        low_p0;
  int                lw_p0;
  logic              ext_p0;
  bundle_t           bundle_p0;

  bundle_t           bundle_out;
  logic              vld_out;

  assign kill   = bus.flush | bus.exc_triggered;
  assign accept = bus.in_valid & in_ready_p0;

  // Stage p0: combinational decode of the offered word against prefix state
  always_comb begin
    is_pfx_p0  = (bus.in_word[15:13] == 3'd4) && (bus.in_word[12:9] == 4'hF);
    t3_p0      = (bus.in_word[15:13] == 3'd3);
    has_imm_p0 = t3_p0 || ((bus.in_word[15:13] == 3'd4) && !is_pfx_p0);
    low_p0     = t3_p0 ? {3'b000, bus.in_word[8:3]} : bus.in_word[8:0];
    lw_p0      = t3_p0 ? 6 : 9;
    ext_p0     = bus.in_sext & ((state == IDLE) ? bus.in_word[8] : pfx_sign);
    full_p0    = (cnt == CNT_W'(EXT_MAX));
    emit_p0    = !is_pfx_p0 || full_p0;

    bundle_p0         = '0;
    bundle_p0.typ     = bus.in_word[15:13];
    bundle_p0.rd      = bus.in_word[2:0];
    bundle_p0.rs0     = t3_p0 ? bus.in_word[2:0] : bus.in_word[5:3];
    bundle_p0.rs1     = bus.in_word[8:6];
    bundle_p0.has_imm = has_imm_p0;

    if (is_pfx_p0) begin
      // only emitted when the prefix budget is exhausted
      bundle_p0.illegal = 1'b1;
    end else if (state == IDLE) begin
      if (has_imm_p0) bundle_p0.imm = compose_imm('0, low_p0, lw_p0, 0, ext_p0);
    end else if (has_imm_p0) begin
      bundle_p0.imm  = compose_imm(acc, low_p0, lw_p0, int'(cnt), ext_p0);
      bundle_p0.npfx = cnt;
    end else begin
      bundle_p0.illegal = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || kill) begin
      state    <= IDLE;
      cnt      <= '0;
      acc      <= '0;
      pfx_sign <= 1'b0;
    end else if (accept) begin
      if (is_pfx_p0 && !full_p0) begin
        acc   <= (acc << 9) | DATA_W'(bus.in_word[8:0]);
        cnt   <= cnt + CNT_W'(1);
        state <= PFX;
        if (state == IDLE) pfx_sign <= bus.in_word[8];
      end else begin
        acc      <= '0;
        cnt      <= '0;
        pfx_sign <= 1'b0;
        state    <= IDLE;
      end
    end
  end

`ifdef DEC_SKID_EN
  bundle_t    q     [3];
  bundle_t    q_n   [3];
  logic [1:0] q_cnt;
  logic [1:0] q_cnt_n;
  logic       ready_r;

  always_comb begin
    q_n     = q;
    q_cnt_n = q_cnt;
    if ((q_cnt != 2'd0) && bus.out_ready) begin
      q_n[0]  = q[1];
      q_n[1]  = q[2];
      q_cnt_n = q_cnt - 2'd1;
    end
    if (accept && emit_p0) begin
      q_n[q_cnt_n] = bundle_p0;
      q_cnt_n      = q_cnt_n + 2'd1;
    end
  end

  // Stage p1: bundle register with skid entries queued behind it
  always_ff @(posedge clk) begin
    if (rst) begin
      q_cnt   <= 2'd0;
      ready_r <= 1'b1;
      for (int i = 0; i < 3; i++) q[i] <= '0;
    end else if (kill) begin
      q_cnt   <= 2'd0;
      ready_r <= 1'b1;
    end else begin
      q       <= q_n;
      q_cnt   <= q_cnt_n;
      ready_r <= (q_cnt_n != 2'd3);
    end
  end

  assign in_ready_p0 = !rst && !kill && ready_r;
  assign bundle_out  = q[0];
  assign vld_out     = (q_cnt != 2'd0);
`else
  bundle_t bundle_p1;
  logic    vld_p1;

  // Stage p1: single bundle register, held until the consumer takes it
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1    <= 1'b0;
      bundle_p1 <= '0;
    end else if (kill) begin
      vld_p1 <= 1'b0;
    end else if (accept && emit_p0) begin
      vld_p1    <= 1'b1;
      bundle_p1 <= bundle_p0;
    end else if (bus.out_ready) begin
      vld_p1 <= 1'b0;
    end
  end

  assign in_ready_p0 = !rst && !kill && (!vld_p1 || bus.out_ready);
  assign bundle_out  = bundle_p1;
  assign vld_out     = vld_p1;
`endif

  assign bus.in_ready    = in_ready_p0;
  assign bus.out_valid   = vld_out;
  assign bus.out_type    = bundle_out.typ;
  assign bus.out_rd      = bundle_out.rd;
  assign bus.out_rs0     = bundle_out.rs0;
  assign bus.out_rs1     = bundle_out.rs1;
  assign bus.out_imm     = bundle_out.imm;
  assign bus.out_has_imm = bundle_out.has_imm;
  assign bus.out_npfx    = bundle_out.npfx;
  assign bus.out_illegal = bundle_out.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: directed scenarios plus randomized traffic checked
// against an arithmetic reference model of prefix folding and flow control.
module tb_decode_stage;
  localparam int DATA_W  = 16;
  localparam int EXT_MAX = 2;
  localparam int CNT_W   = 2;

  typedef struct packed {
    logic [2:0]  typ;
    logic [2:0]  rd;
    logic [2:0]  rs0;
    logic [2:0]  rs1;
    logic [15:0] imm;
    logic        has;
    logic [1:0]  npfx;
    logic        ill;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   n_chk  = 0;
  int   n_pass = 0;

  logic        m_vld;
  exp_t        m_b;
  int unsigned pq[$];

  decode_if #(.DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();

  decode_stage #(.DATA_W(DATA_W), .EXT_MAX(EXT_MAX), .CNT_W(CNT_W)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
  endtask

  // Reference: fold prefixes arithmetically, then sign-adjust by the full width.
  task automatic model_word(input logic [15:0] w, input logic sx);
    int     typ;
    bit     pfx;
    bit     has;
    int     lw;
    int     n;
    int     width;
    longint lval;
    longint v;
    bit     sign;
    exp_t   b;
    typ = int'(w[15:13]);
    pfx = (typ == 4) && (w[12:9] == 4'hF);
    if (pfx && pq.size() < EXT_MAX) begin
      pq.push_back(int'(w[8:0]));
      return;
    end
    b     = '0;
    b.typ = w[15:13];
    b.rd  = w[2:0];
    b.rs0 = (typ == 3) ? w[2:0] : w[5:3];
    b.rs1 = w[8:6];
    has   = (typ == 3) || (typ == 4 && !pfx);
    b.has = has;
    if (pfx || (!has && pq.size() > 0)) begin
      b.ill = 1'b1;
    end else if (has) begin
      n    = pq.size();
      lw   = (typ == 3) ? 6 : 9;
      lval = (typ == 3) ? longint'(w[8:3]) : longint'(w[8:0]);
      v    = 0;
      foreach (pq[k]) v = v * 512 + longint'(pq[k]);
      v     = v * (longint'(1) << lw) + lval;
      width = 9 * n + lw;
      sign  = (n > 0) ? (((pq[0] >> 8) & 1) == 1) : w[8];
      if (sx && sign) v = v - (longint'(1) << width);
      b.imm  = v[15:0];
      b.npfx = 2'(n);
    end
    pq.delete();
    m_b   = b;
    m_vld = 1'b1;
  endtask

  task automatic step(input logic [15:0] w, input logic sx, input logic v,
                      input logic ordy, input logic fl, input logic ex);
    logic m_ready;
    bus.in_word       = w;
    bus.in_sext       = sx;
    bus.in_valid      = v;
    bus.out_ready     = ordy;
    bus.flush         = fl;
    bus.exc_triggered = ex;
    #1;
    m_ready = !fl && !ex && (!m_vld || ordy);
    chk("in_ready", 64'(bus.in_ready), 64'(m_ready));
    chk("out_valid", 64'(bus.out_valid), 64'(m_vld));
    if (m_vld) begin
      chk("out_type", 64'(bus.out_type), 64'(m_b.typ));
      chk("out_rd", 64'(bus.out_rd), 64'(m_b.rd));
      chk("out_rs0", 64'(bus.out_rs0), 64'(m_b.rs0));
      chk("out_rs1", 64'(bus.out_rs1), 64'(m_b.rs1));
      chk("out_imm", 64'(bus.out_imm), 64'(m_b.imm));
      chk("out_has_imm", 64'(bus.out_has_imm), 64'(m_b.has));
      chk("out_npfx", 64'(bus.out_npfx), 64'(m_b.npfx));
      chk("out_illegal", 64'(bus.out_illegal), 64'(m_b.ill));
    end
    if (fl || ex) begin
      m_vld = 1'b0;
      pq.delete();
    end else begin
      if (m_vld && ordy) m_vld = 1'b0;
      if (v && m_ready) model_word(w, sx);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [15:0] w;
    logic [12:0] r13;
    logic [8:0]  r9;
    logic [3:0]  r4;

    m_vld             = 1'b0;
    m_b               = '0;
    rst               = 1'b1;
    bus.in_word       = '0;
    bus.in_sext       = 1'b0;
    bus.in_valid      = 1'b1;
    bus.out_ready     = 1'b1;
    bus.flush         = 1'b0;
    bus.exc_triggered = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 64'(bus.in_ready), 64'd0);
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_imm", 64'(bus.out_imm), 64'd0);
    chk("rst_npfx", 64'(bus.out_npfx), 64'd0);
    chk("rst_illegal", 64'(bus.out_illegal), 64'd0);
    chk("rst_has_imm", 64'(bus.out_has_imm), 64'd0);
    chk("rst_fields", 64'({bus.out_type, bus.out_rd, bus.out_rs0, bus.out_rs1}), 64'd0);
    rst = 1'b0;

    // single type-3 word, sign-extended
    step(16'h6150, 1, 1, 1, 0, 0);
    chk("t1_valid", 64'(bus.out_valid), 64'd1);
    chk("t1_type", 64'(bus.out_type), 64'd3);
    chk("t1_imm", 64'(bus.out_imm), 64'hFFEA);
    chk("t1_rs0", 64'(bus.out_rs0), 64'd0);
    chk("t1_rs1", 64'(bus.out_rs1), 64'd5);
    chk("t1_has_imm", 64'(bus.out_has_imm), 64'd1);
    chk("t1_npfx", 64'(bus.out_npfx), 64'd0);

    // one prefix folded into a type-4 imm9
    step(16'h9FFF, 0, 1, 1, 0, 0);
    chk("t2_no_bundle", 64'(bus.out_valid), 64'd0);
    step(16'h8034, 0, 1, 1, 0, 0);
    chk("t2_imm", 64'(bus.out_imm), 64'hFE34);
    chk("t2_npfx", 64'(bus.out_npfx), 64'd1);
    chk("t2_illegal", 64'(bus.out_illegal), 64'd0);
    step(16'h0000, 0, 0, 1, 0, 0);
    chk("t2_single", 64'(bus.out_valid), 64'd0);

    // one prefix folded into a type-3 imm6
    step(16'h9E01, 0, 1, 1, 0, 0);
    step(16'h6150, 0, 1, 1, 0, 0);
    chk("t3_imm", 64'(bus.out_imm), 64'h006A);
    chk("t3_npfx", 64'(bus.out_npfx), 64'd1);

    // prefix overflow
    step(16'h9E01, 0, 1, 1, 0, 0);
    step(16'h9E01, 0, 1, 1, 0, 0);
    step(16'h9E01, 0, 1, 1, 0, 0);
    chk("t4_valid", 64'(bus.out_valid), 64'd1);
    chk("t4_illegal", 64'(bus.out_illegal), 64'd1);
    chk("t4_imm", 64'(bus.out_imm), 64'd0);
    step(16'h6150, 0, 1, 1, 0, 0);
    chk("t4_next_npfx", 64'(bus.out_npfx), 64'd0);
    chk("t4_next_imm", 64'(bus.out_imm), 64'h002A);

    // prefix before an instruction without an immediate
    step(16'h9E01, 0, 1, 1, 0, 0);
    step(16'h0008, 0, 1, 1, 0, 0);
    chk("t5_illegal", 64'(bus.out_illegal), 64'd1);
    step(16'h6150, 1, 1, 1, 0, 0);
    chk("t5_next_illegal", 64'(bus.out_illegal), 64'd0);
    chk("t5_next_imm", 64'(bus.out_imm), 64'hFFEA);

    // stall with a pending bundle, then flush it
    for (int i = 0; i < 3; i++) begin
      step(16'h9E01, 0, 1, 0, 0, 0);
      chk("t6_stall_valid", 64'(bus.out_valid), 64'd1);
      chk("t6_stall_imm", 64'(bus.out_imm), 64'hFFEA);
    end
    step(16'h9E01, 0, 1, 0, 1, 0);
    chk("t6_flush_valid", 64'(bus.out_valid), 64'd0);

    // prefix discarded by flush, then by exception
    step(16'h9E01, 0, 1, 1, 0, 0);
    step(16'h6150, 0, 1, 1, 1, 0);
    step(16'h6150, 0, 1, 1, 0, 0);
    chk("t7_npfx", 64'(bus.out_npfx), 64'd0);
    chk("t7_imm", 64'(bus.out_imm), 64'h002A);
    step(16'h9E01, 0, 1, 1, 0, 0);
    step(16'h6150, 0, 1, 1, 0, 1);
    step(16'h8034, 1, 1, 1, 0, 0);
    chk("t8_npfx", 64'(bus.out_npfx), 64'd0);
    chk("t8_imm", 64'(bus.out_imm), 64'h0034);

    // randomized traffic
    for (int c = 0; c < 600; c++) begin
      r13 = 13'($urandom);
      r9  = 9'($urandom);
      r4  = 4'($urandom_range(0, 14));
      case ($urandom_range(0, 3))
        0:       w = {7'b1001111, r9};
        1:       w = {3'd3, r13};
        2:       w = {3'd4, r4, r9};
        default: w = 16'($urandom);
      endcase
      step(w, 1'($urandom), ($urandom_range(0, 4) != 0), ($urandom_range(0, 9) < 7),
           ($urandom_range(0, 29) == 0), ($urandom_range(0, 29) == 0));
    end
    step(16'h0000, 0, 0, 1, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Registered, handshaked instruction-decode stage. Generalises the combinational instruction decoder to a parametrised immediate width.
- Adds multi-word immediate prefixes, flush/exception kill, and valid/ready flow control.
- Sits between the fetch word stream and the microcode sequencer. It emits one decoded bundle per non-prefix instruction.

Parameters:
- DATA_W, 16, width of the composed immediate output (>= 9).
- EXT_MAX, 2, maximum consecutive prefix words accepted before an instruction (1..4).
- CNT_W, 2, width of the prefix counter; must hold EXT_MAX.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_word  in  16  instruction word.
- in_sext  in  1  sign-extend request, sampled with in_word.
- in_valid  in  1  in_word is valid.
- in_ready  out  1  stage accepts in_word this cycle.
- flush  in  1  discard pending prefixes and the output bundle.
- exc_triggered  in  1  an exception is pending; treated as flush.
- out_valid  out  1  decoded bundle valid.
- out_ready  in  1  consumer takes the bundle.
- out_type  out  3  in_word[15:13] of the decoded word.
- out_rd  out  3  in_word[2:0].
- out_rs0  out  3  in_word[2:0] when type==3, else in_word[5:3].
- out_rs1  out  3  in_word[8:6].
- out_imm  out  DATA_W  composed immediate.
- out_has_imm  out  1  word is type 3 (imm6) or a non-prefix type 4 (imm9).
- out_npfx  out  CNT_W  number of prefixes folded into out_imm.
- out_illegal  out  1  prefix-sequence violation.

Behaviour:
- Field definitions:
  - Prefix word: in_word[15:13]==3'b100 and in_word[12:9]==4'hF. Payload is in_word[8:0].
  - Low field L: in_word[8:3] (6 bits) for type 3; in_word[8:0] (9 bits) for a non-prefix type 4.
- Reset: while rst=1, in_ready=0.
  - Next cycle all outputs are 0: out_valid, out_imm, out_npfx, out_illegal, out_has_imm, and all register fields.
  - Prefix count and prefix accumulator are cleared.
- Handshakes:
  - An input transfer occurs when in_valid && in_ready.
  - An output transfer occurs when out_valid && out_ready.
  - out_valid is held, with the bundle stable, until it is taken.
- Without DEC_SKID_EN: in_ready = !rst && !flush && !exc_triggered && (!out_valid || out_ready).
- FSM states:
  - IDLE (count 0).
  - PFX (count 1..EXT_MAX).
- Accepted prefix:
  - If count < EXT_MAX: acc <= {acc, payload} (shift left 9, OR payload). The sign bit is the payload's bit 8 when it is the first prefix. count++, state PFX. No output is produced.
  - If count == EXT_MAX: emit a bundle with out_illegal=1, out_imm=0 and fields from the word, then return to IDLE.
- Accepted non-prefix word: the bundle is registered, so out_valid is 1 the cycle after the transfer (latency 1). The FSM returns to IDLE.
  - count==0: out_imm = L, sign-extended to DATA_W if in_sext, else zero-extended.
  - count>0 and out_has_imm: out_imm = {acc, L} truncated to DATA_W. The extension above the concatenation comes from the first prefix's bit 8 if in_sext, else zeros. out_npfx = count.
  - count>0 and !out_has_imm: out_illegal=1, out_imm=0.
- flush or exc_triggered high in a cycle:
  - Same cycle: in_ready=0.
  - Next edge: out_valid<=0, count<=0, acc<=0, state<=IDLE.
  - Takes priority over any simultaneous input or output transfer; an output transfer in that cycle still counts as taken by the consumer.
- Stall: with out_valid=1 and out_ready=0, no input is accepted and prefix state is frozen.
- Back-to-back operation: input and output transfers in the same cycle sustain 1 word/cycle.

Optional Feature:
- Macro: DEC_SKID_EN.
- Defined:
  - A 2-entry skid buffer is placed behind the bundle register.
  - in_ready = !rst && !flush && !exc_triggered && (skid not full), a registered value independent of out_ready.
  - Order is preserved; flush empties the skid.
  - Latency is 1 when the skid is empty.
- Undefined: no skid. in_ready depends combinationally on out_ready as stated above.

Test Plan:
- Reset then in_word=0x6150, in_sext=1, out_ready=1 -> next cycle out_valid=1, out_type=3, out_imm=0xFFEA, out_rs0=0, out_rs1=5, out_has_imm=1, out_npfx=0.
- Prefix 0x9FFF then 0x8034, in_sext=0 -> exactly one bundle: out_imm=0xFE34, out_npfx=1, out_illegal=0.
- Prefix 0x9E01 then 0x6150, in_sext=0 -> out_imm=0x006A, out_npfx=1.
- Three prefixes 0x9E01 with EXT_MAX=2 -> third word yields out_illegal=1, out_imm=0; following 0x6150 decodes with out_npfx=0.
- Prefix 0x9E01 then 0x0008 (type 0) -> out_illegal=1; next word decodes normally.
- out_ready=0 for 3 cycles with bundle pending, then flush=1 -> bundle stable during stall; out_valid=0 after flush; a prefix accepted before the flush is discarded.
